alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Controller sitting between the UART receiver/transmitter and the ALU. Parses tagged byte pairs from `uart_rx` into operand A, operand B and opcode registers. On each opcode pair it launches one ALU evaluation, captures the result and hands it to `uart_tx`, blocking new commands until the transmit completes. It also enforces an inter-byte timeout and reports protocol errors.

## Interface
- `NB_DATA`, 8: data/operand width
- `NB_OP`, 6: opcode width
- `NB_TMO`, 16: timeout counter width
- `TIMEOUT`, 50000: maximum cycles allowed between a tag byte and its value byte

- `clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_rx`  in  NB_DATA  received byte, valid while `i_rx_done`=1
- `i_rx_done`  in  1  one-cycle strobe per received byte
- `i_tx_done`  in  1  one-cycle strobe, transmitter finished byte
- `o_tx_start`  out  1  one-cycle strobe, start transmit
- `o_tx_data`  out  NB_DATA  byte to transmit (registered)
- `o_datoA`  out  NB_DATA  ALU operand A (registered)
- `o_datoB`  out  NB_DATA  ALU operand B (registered)
- `o_operation`  out  NB_OP  ALU opcode (registered)
- `o_valid`  out  1  one-cycle ALU launch strobe
- `i_result`  in  NB_DATA  ALU result, combinational from `o_datoA`/`o_datoB`/`o_operation`
- `o_busy`  out  1  high outside IDLE/DATA
- `o_err`  out  1  one-cycle error strobe
- `o_err_code`  out  2  last error: 01 bad tag, 10 timeout, 11 overrun; held until next error

## Operation
- Reset: state IDLE; all outputs 0; timeout counter 0.
- Tags are `i_rx[NB_OP-1:0]`: 6'b001000 = A, 6'b010000 = B, 6'b100000 = OP. Upper tag bits are ignored.
- IDLE: on `i_rx_done`, a valid tag is latched and the FSM goes to DATA with the counter cleared. An invalid tag raises error 01 and the FSM stays in IDLE.
- DATA: the counter increments every cycle.
  - On `i_rx_done` with tag A or B, the byte is written to `o_datoA` or `o_datoB` and the FSM returns to IDLE.
  - On `i_rx_done` with tag OP, `i_rx[NB_OP-1:0]` is written to `o_operation` and the FSM goes to EXEC.
  - If the counter reaches TIMEOUT-1 without a byte, error 10 is raised, the FSM returns to IDLE, and the operand registers are unchanged.
  - If `i_rx_done` and the terminal count coincide, the byte wins.
- EXEC: `o_valid`=1 for exactly one cycle, then CAPTURE.
- CAPTURE: `i_result` is registered into `o_tx_data`, then TX.
- TX: `o_tx_start`=1 for one cycle, then WAIT_TX.
- WAIT_TX: the FSM waits for `i_tx_done` (no timeout), then returns to IDLE or STATUS (see Configuration).
- Overrun: `i_rx_done` in EXEC/CAPTURE/TX/WAIT_TX/STATUS drops the byte and raises error 11. The FSM does not change state.
- Operand registers persist across commands. An OP-only command reuses the previous A and B.
- `o_err` is asserted in the cycle after the detecting edge. `o_err_code` updates in the same cycle.
- `i_rst` asserted in any state returns to reset values at the next edge, including dropping `o_tx_start` and `o_valid`.

## Timing
- The value byte of an OP pair (`i_rx_done` in DATA) is sampled at edge N:
  - `o_valid`=1 in cycle N+1.
  - `o_tx_data` is valid from N+2.
  - `o_tx_start`=1 in cycle N+3.
- `o_busy` is high from cycle N+1 until the cycle after `i_tx_done` is sampled.
- Operands are stable throughout EXEC and CAPTURE.
- An `i_tx_done` seen outside WAIT_TX/STATUS-wait is ignored.

## Configuration
- `ALU_SEQ_STATUS_EN` defined: after WAIT_TX the FSM enters STATUS.
  - STATUS sends a second byte: 0x00 if no error occurred since the previous command, otherwise {6'b111000, last `o_err_code`}.
  - The byte is sent with `o_tx_start` pulsing the cycle after entering STATUS, and the FSM waits for `i_tx_done`, then IDLE.
  - The error-since-last flag is cleared on STATUS exit.
- Undefined: STATUS is absent. WAIT_TX goes directly to IDLE. Errors are visible only on `o_err`/`o_err_code`.

## Test plan
- Send 0x08,0x05, 0x10,0x03, 0x20,0x20; ALU model returns 0x08 → `o_datoA`=0x05, `o_datoB`=0x03, `o_operation`=0x20, one `o_valid`, `o_tx_data`=0x08, single `o_tx_start` at N+3; return to IDLE after `i_tx_done`.
- Repeat OP pair 0x20,0x22 only → previous A/B reused, `o_operation`=0x22, one transmit.
- Tag 0x04 → `o_err` pulse, `o_err_code`=01, no register change; with `ALU_SEQ_STATUS_EN`, the next command's status byte = 0xE1.
- Tag 0x08 then silence for TIMEOUT cycles (TIMEOUT=20 in bench) → `o_err_code`=10 at cycle 20, `o_datoA` unchanged. A byte arriving exactly at cycle 19 is accepted instead.
- Byte during WAIT_TX → `o_err_code`=11, byte dropped, FSM still waits for `i_tx_done`.
- `i_rst` asserted in WAIT_TX and in DATA → all outputs 0 next cycle, state IDLE; a new full command then succeeds.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between UART rx/tx and the ALU: parses tagged byte pairs, launches
// one ALU evaluation per opcode pair and transmits the result. Optional: ALU_SEQ_STATUS_EN.
module alu_cmd_sequencer #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_TMO  = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    typedef enum logic [2:0] {
        StIdle, StData, StExec, StCapture, StTx, StWaitTx, StStatus, StStatusWait
    } state_e;

    localparam logic [NB_OP-1:0]  TagA    = NB_OP'(8);
    localparam logic [NB_OP-1:0]  TagB    = NB_OP'(16);
    localparam logic [NB_OP-1:0]  TagOp   = NB_OP'(32);
    localparam logic [1:0]        SelA    = 2'd0;
    localparam logic [1:0]        SelB    = 2'd1;
    localparam logic [1:0]        SelOp   = 2'd2;
    localparam logic [NB_TMO-1:0] TmoLast = NB_TMO'(TIMEOUT - 1);
    localparam logic [1:0]        ErrTag  = 2'b01;
    localparam logic [1:0]        ErrTmo  = 2'b10;
    localparam logic [1:0]        ErrOvr  = 2'b11;

    state_e               state_q, state_d;
    logic [1:0]           tag_q, tag_d;
    logic [NB_TMO-1:0]    cnt_q, cnt_d;
    logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
    logic [NB_OP-1:0]     op_q, op_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [NB_OP-1:0]     rx_tag;
    logic                 tag_valid;
    logic                 timed_out;
    logic                 in_cmd;

    assign rx_tag    = i_rx[NB_OP-1:0];
    assign tag_valid = (rx_tag == TagA) || (rx_tag == TagB) || (rx_tag == TagOp);
    assign timed_out = (state_q == StData) && !i_rx_done && (cnt_q == TmoLast);
    assign in_cmd    = (state_q == StIdle) || (state_q == StData);

`ifdef ALU_SEQ_STATUS_EN
    logic               err_seen_q, err_seen_d;
    logic [NB_DATA-1:0] status_byte;

    assign status_byte = err_seen_q ? NB_DATA'({6'b111000, err_code_q}) : '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (i_rx_done && tag_valid) state_d = StData;
            StData: begin
                if (i_rx_done) begin
                    state_d = (tag_q == SelOp) ? StExec : StIdle;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StExec:    state_d = StCapture;
            StCapture: state_d = StTx;
            StTx:      state_d = StWaitTx;
            StWaitTx: begin
`ifdef ALU_SEQ_STATUS_EN
                if (i_tx_done) state_d = StStatus;
`else
                if (i_tx_done) state_d = StIdle;
`endif
            end
            StStatus:     state_d = StStatusWait;
            StStatusWait: if (i_tx_done) state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        o_valid    = (state_q == StExec);
        o_tx_start = (state_q == StTx) || (state_q == StStatus);
        o_busy     = !in_cmd;
    end

    always_comb begin
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        case (state_q)
            StIdle: begin
                if (i_rx_done) begin
                    if (tag_valid) begin
                        tag_d = (rx_tag == TagA) ? SelA : (rx_tag == TagB) ? SelB : SelOp;
                        cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrTag;
                    end
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (i_rx_done) begin
                    if (tag_q == SelA) begin
                        dato_a_d = i_rx;
                    end else if (tag_q == SelB) begin
                        dato_b_d = i_rx;
                    end else begin
                        op_d = rx_tag;
                    end
                end else if (timed_out) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTmo;
                end
            end
            // Result is already settled from the operands registered on the previous edge
            StExec: tx_data_d = i_result;
`ifdef ALU_SEQ_STATUS_EN
            StWaitTx: if (i_tx_done) tx_data_d = status_byte;
`endif
            default: ;
        endcase
        if (i_rx_done && !in_cmd) begin
            err_d      = 1'b1;
            err_code_d = ErrOvr;
        end
    end

`ifdef ALU_SEQ_STATUS_EN
    always_comb begin
        err_seen_d = err_seen_q;
        if ((state_q == StStatusWait) && i_tx_done) err_seen_d = 1'b0;
        if (err_d) err_seen_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            err_seen_q <= 1'b0;
        end else begin
            err_seen_q <= err_seen_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            tag_q      <= SelA;
            cnt_q      <= '0;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_datoA     = dato_a_q;
    assign o_datoB     = dato_b_q;
    assign o_operation = op_q;
    assign o_tx_data   = tx_data_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;

endmodule
